// File: rtl/stack_param.sv
// LIFO stack with random-access read from the top, registered read port,
// and one-cycle ERROR / O_VALID status pulses. One command per clock.
module stack_param #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [2:0]       COMMAND,
    input  logic [AW-1:0]    INDEX,
    input  logic [WIDTH-1:0] I_DATA,
    output logic [WIDTH-1:0] O_DATA,
    output logic             O_VALID,
    output logic             ERROR,
    output logic [CW-1:0]    COUNT,
    output logic             FULL,
    output logic             EMPTY
);

    typedef enum logic [2:0] {
        CMD_NOP     = 3'b000,
        CMD_PUSH    = 3'b001,
        CMD_POP     = 3'b010,
        CMD_GET     = 3'b011,
        CMD_CLEAR   = 3'b100,
        CMD_REPLACE = 3'b101
    } cmd_t;

    cmd_t             cmd;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    top_addr;
    logic [AW-1:0]    rd_addr;
    logic [AW-1:0]    wr_addr;
    logic             push_ok;
    logic             pop_ok;
    logic             get_ok;
    logic             rep_ok;
    logic             rd_ok;
    logic             cmd_err;

    assign cmd      = cmd_t'(COMMAND);
    assign FULL     = (COUNT == CW'(DEPTH));
    assign EMPTY    = (COUNT == '0);
    // Only meaningful when COUNT > 0; every user is gated by a legality check.
    assign top_addr = AW'(COUNT - CW'(1));
    assign rd_ok    = pop_ok | get_ok;
    assign rd_addr  = get_ok ? (top_addr - INDEX) : top_addr;
    assign wr_addr  = push_ok ? AW'(COUNT) : top_addr;

    // Command decode: legality of each command and the error pulse source.
    always_comb begin
        push_ok = 1'b0;
        pop_ok  = 1'b0;
        get_ok  = 1'b0;
        rep_ok  = 1'b0;
        cmd_err = 1'b0;
        case (cmd)
            CMD_NOP, CMD_CLEAR: ;
            CMD_PUSH: begin
                push_ok = !FULL;
                cmd_err = FULL;
            end
            CMD_POP: begin
                pop_ok  = !EMPTY;
                cmd_err = EMPTY;
            end
            CMD_GET: begin
                get_ok  = (CW'(INDEX) < COUNT);
                cmd_err = !(CW'(INDEX) < COUNT);
            end
            CMD_REPLACE: begin
                rep_ok  = !EMPTY;
                cmd_err = EMPTY;
            end
            default: cmd_err = 1'b1;
        endcase
    end

    // Storage array; contents are never reset since reads stay below COUNT.
    always_ff @(posedge CLK) begin
        if (push_ok || rep_ok) begin
            mem[wr_addr] <= I_DATA;
        end
    end

    // Count, registered read data and status pulses.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            COUNT   <= '0;
            O_DATA  <= '0;
            O_VALID <= 1'b0;
            ERROR   <= 1'b0;
        end else begin
            O_VALID <= rd_ok;
            ERROR   <= cmd_err;
            if (rd_ok) begin
                O_DATA <= mem[rd_addr];
            end
            if (push_ok) begin
                COUNT <= COUNT + CW'(1);
            end else if (pop_ok) begin
                COUNT <= COUNT - CW'(1);
            end else if (cmd == CMD_CLEAR) begin
                COUNT <= '0;
            end
        end
    end

endmodule

// File: tb/tb_stack_param.sv
// Directed bench for stack_param at three parameter points, checked
// against a behavioural stack model through an expected-result queue.
module tb_stack_param;

    logic CLK = 1'b0;
    logic RESET = 1'b0;
    always #5 CLK = ~CLK;

    logic [2:0]  cmd [3];
    logic [7:0]  idx [3];
    logic [31:0] din [3];

    logic [3:0]  dout0;
    logic [15:0] dout1;
    logic [0:0]  dout2;
    logic [3:0]  cnt0;
    logic [5:0]  cnt1;
    logic [1:0]  cnt2;
    logic        vld0, vld1, vld2;
    logic        err0, err1, err2;
    logic        full0, full1, full2;
    logic        emp0, emp1, emp2;

    stack_param u_def (
        .CLK(CLK), .RESET(RESET), .COMMAND(cmd[0]), .INDEX(idx[0][2:0]),
        .I_DATA(din[0][3:0]), .O_DATA(dout0), .O_VALID(vld0), .ERROR(err0),
        .COUNT(cnt0), .FULL(full0), .EMPTY(emp0)
    );

    stack_param #(.WIDTH(16), .DEPTH(32)) u_wide (
        .CLK(CLK), .RESET(RESET), .COMMAND(cmd[1]), .INDEX(idx[1][4:0]),
        .I_DATA(din[1][15:0]), .O_DATA(dout1), .O_VALID(vld1), .ERROR(err1),
        .COUNT(cnt1), .FULL(full1), .EMPTY(emp1)
    );

    stack_param #(.WIDTH(1), .DEPTH(2)) u_narrow (
        .CLK(CLK), .RESET(RESET), .COMMAND(cmd[2]), .INDEX(idx[2][0:0]),
        .I_DATA(din[2][0:0]), .O_DATA(dout2), .O_VALID(vld2), .ERROR(err2),
        .COUNT(cnt2), .FULL(full2), .EMPTY(emp2)
    );

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, GET = 3'd3,
                           CLEAR = 3'd4, REPLACE = 3'd5, RSVD = 3'd6;

    typedef struct {
        logic        v;
        logic        e;
        logic [31:0] d;
        int          c;
        logic        full;
        logic        empty;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] mm [3][256];
    int          mc [3];
    logic [31:0] md [3];
    int          checks = 0;
    int          errors = 0;

    function automatic int wd(int i);
        case (i)
            0: return 4;
            1: return 16;
            default: return 1;
        endcase
    endfunction

    function automatic int dp(int i);
        case (i)
            0: return 8;
            1: return 32;
            default: return 2;
        endcase
    endfunction

    function automatic logic [31:0] mask(int i);
        return (32'd1 << wd(i)) - 32'd1;
    endfunction

    function automatic logic [31:0] o_data(int i);
        case (i)
            0: return 32'(dout0);
            1: return 32'(dout1);
            default: return 32'(dout2);
        endcase
    endfunction

    function automatic int o_count(int i);
        case (i)
            0: return int'(cnt0);
            1: return int'(cnt1);
            default: return int'(cnt2);
        endcase
    endfunction

    function automatic logic [3:0] o_flags(int i);
        case (i)
            0: return {vld0, err0, full0, emp0};
            1: return {vld1, err1, full1, emp1};
            default: return {vld2, err2, full2, emp2};
        endcase
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one command, predict its outcome, then compare one cycle later.
    task automatic issue(int i, logic [2:0] c, int ix, logic [31:0] dat);
        exp_t        e;
        logic [3:0]  f;
        logic [31:0] m;
        int          d;
        m = mask(i);
        d = dp(i);
        @(negedge CLK);
        cmd[i] = c;
        idx[i] = 8'(ix);
        din[i] = dat;
        e.v = 1'b0;
        e.e = 1'b0;
        case (c)
            NOP: ;
            PUSH: if (mc[i] < d) begin mm[i][mc[i]] = dat & m; mc[i]++; end
                  else e.e = 1'b1;
            POP: if (mc[i] > 0) begin mc[i]--; md[i] = mm[i][mc[i]]; e.v = 1'b1; end
                 else e.e = 1'b1;
            GET: if (ix < mc[i]) begin md[i] = mm[i][mc[i] - 1 - ix]; e.v = 1'b1; end
                 else e.e = 1'b1;
            CLEAR: mc[i] = 0;
            REPLACE: if (mc[i] > 0) mm[i][mc[i] - 1] = dat & m;
                     else e.e = 1'b1;
            default: e.e = 1'b1;
        endcase
        e.d     = md[i];
        e.c     = mc[i];
        e.full  = (mc[i] == d);
        e.empty = (mc[i] == 0);
        sb.push_back(e);
        @(posedge CLK);
        #1;
        cmd[i] = NOP;
        e = sb.pop_front();
        f = o_flags(i);
        chk($sformatf("i%0d_cmd%0d_valid", i, c), 32'(f[3]), 32'(e.v));
        chk($sformatf("i%0d_cmd%0d_error", i, c), 32'(f[2]), 32'(e.e));
        chk($sformatf("i%0d_cmd%0d_data", i, c), o_data(i), e.d);
        chk($sformatf("i%0d_cmd%0d_count", i, c), 32'(o_count(i)), 32'(e.c));
        chk($sformatf("i%0d_cmd%0d_full", i, c), 32'(f[1]), 32'(e.full));
        chk($sformatf("i%0d_cmd%0d_empty", i, c), 32'(f[0]), 32'(e.empty));
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mc[i]  = 0;
            md[i]  = '0;
            cmd[i] = NOP;
        end
        #2;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("i%0d_rst_count", i), 32'(o_count(i)), 32'd0);
            chk($sformatf("i%0d_rst_data", i), o_data(i), 32'd0);
            chk($sformatf("i%0d_rst_flags", i), 32'(o_flags(i)), 32'b0001);
        end
        @(negedge CLK);
        RESET = 1'b1;
    endtask

    // Defaults, fill/overflow and drain/underflow at one parameter point.
    task automatic run_basic(int i);
        logic [31:0] v [3];
        logic [31:0] m;
        int          n;
        int          d;
        m = mask(i);
        d = dp(i);
        v[0] = (i == 1) ? 32'h3a53 : ((i == 2) ? 32'd1 : 32'd3);
        v[1] = (i == 1) ? 32'h5c35 : ((i == 2) ? 32'd0 : 32'd5);
        v[2] = (i == 1) ? 32'h9e99 : 32'd9;
        n = (d < 3) ? d : 3;
        for (int k = 0; k < n; k++) issue(i, PUSH, 0, v[k]);
        issue(i, GET, 0, 0);
        chk($sformatf("i%0d_get_top", i), o_data(i), v[n-1] & m);
        issue(i, GET, n - 1, 0);
        chk($sformatf("i%0d_get_bottom", i), o_data(i), v[0] & m);
        chk($sformatf("i%0d_get_bottom_valid", i), 32'(o_flags(i) >> 3), 32'd1);
        chk($sformatf("i%0d_count_after_get", i), 32'(o_count(i)), 32'(n));

        issue(i, CLEAR, 0, 0);
        for (int k = 0; k < d; k++) issue(i, PUSH, 0, 32'(k));
        chk($sformatf("i%0d_fill_full", i), 32'(o_flags(i) >> 1 & 4'd1), 32'd1);
        issue(i, PUSH, 0, 32'h5);
        chk($sformatf("i%0d_overflow_err", i), 32'(o_flags(i) >> 2 & 4'd1), 32'd1);
        chk($sformatf("i%0d_overflow_count", i), 32'(o_count(i)), 32'(d));
        issue(i, POP, 0, 0);
        chk($sformatf("i%0d_pop_after_fill", i), o_data(i), 32'(d - 1) & m);

        issue(i, PUSH, 0, 32'(d - 1));
        for (int k = d - 1; k >= 0; k--) begin
            issue(i, POP, 0, 0);
            chk($sformatf("i%0d_drain_%0d", i, k), o_data(i), 32'(k) & m);
        end
        chk($sformatf("i%0d_drained_empty", i), 32'(o_flags(i) & 4'd1), 32'd1);
        issue(i, POP, 0, 0);
        chk($sformatf("i%0d_underflow_err", i), 32'(o_flags(i) >> 2 & 4'd1), 32'd1);
        chk($sformatf("i%0d_underflow_data", i), o_data(i), 32'd0);
        issue(i, GET, 0, 0);
        chk($sformatf("i%0d_get_empty_err", i), 32'(o_flags(i) >> 2 & 4'd1), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "bench timeout");
    end

    initial begin
        for (int i = 0; i < 3; i++) begin
            cmd[i] = NOP;
            idx[i] = '0;
            din[i] = '0;
        end
        apply_reset();

        for (int i = 0; i < 3; i++) run_basic(i);

        // Bad index, REPLACE, CLEAR and reserved codes on the default instance.
        issue(0, PUSH, 0, 32'hA);
        issue(0, PUSH, 0, 32'hB);
        issue(0, GET, 2, 0);
        chk("bad_index_err", 32'(err0), 32'd1);
        issue(0, GET, 1, 0);
        chk("get_index1", 32'(dout0), 32'hA);
        issue(0, REPLACE, 0, 32'hC);
        issue(0, POP, 0, 0);
        chk("pop_replaced", 32'(dout0), 32'hC);
        issue(0, RSVD, 0, 0);
        issue(0, 3'd7, 0, 0);
        chk("reserved_err", 32'(err0), 32'd1);
        issue(0, NOP, 0, 0);
        issue(0, CLEAR, 0, 0);
        chk("clear_count", 32'(cnt0), 32'd0);
        chk("clear_empty", 32'(emp0), 32'd1);
        chk("clear_keeps_data", 32'(dout0), 32'hC);
        issue(0, REPLACE, 0, 32'h3);
        issue(0, PUSH, 0, 32'h6);
        issue(0, POP, 0, 0);
        chk("push_pop_back_to_back", 32'(dout0), 32'h6);

        // Asynchronous reset between edges.
        for (int k = 1; k <= 4; k++) issue(0, PUSH, 0, 32'(k));
        issue(0, GET, 0, 0);
        #2;
        RESET = 1'b0;
        #1;
        chk("async_rst_count", 32'(cnt0), 32'd0);
        chk("async_rst_data", 32'(dout0), 32'd0);
        chk("async_rst_empty", 32'(emp0), 32'd1);
        for (int i = 0; i < 3; i++) begin
            mc[i] = 0;
            md[i] = '0;
        end
        @(negedge CLK);
        RESET = 1'b1;
        issue(0, PUSH, 0, 32'hE);
        issue(0, POP, 0, 0);
        chk("after_rst_pop", 32'(dout0), 32'hE);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_param.md
STACK_PARAM -- requirements
Module: stack_param

Interface
REQ-001 Parameter WIDTH, default 4: data word width in bits, legal range 1..32.
REQ-002 Parameter DEPTH, default 8: number of entries, a power of two, legal range 2..256.
REQ-003 Derived widths: AW = clog2(DEPTH); CW = clog2(DEPTH+1).
REQ-004 CLK  input  1: single clock; all state changes on rising edge.
REQ-005 RESET  input  1: asynchronous, active-low reset.
REQ-006 COMMAND  input  3: 000 NOP, 001 PUSH, 010 POP, 011 GET, 100 CLEAR, 101 REPLACE; 110/111 reserved.
REQ-007 INDEX  input  AW: GET depth from top; 0 = top element.
REQ-008 I_DATA  input  WIDTH: data for PUSH and REPLACE.
REQ-009 O_DATA  output  WIDTH: registered read result.
REQ-010 O_VALID  output  1: one-cycle pulse, O_DATA updated by a successful POP or GET.
REQ-011 ERROR  output  1: one-cycle pulse, previous command rejected.
REQ-012 COUNT  output  CW: current number of stored entries.
REQ-013 FULL  output  1: COUNT == DEPTH, combinational from COUNT.
REQ-014 EMPTY  output  1: COUNT == 0, combinational from COUNT.

Function
REQ-015 COMMAND, INDEX and I_DATA are sampled on each rising CLK edge; exactly one command executes per cycle.
REQ-016 PUSH when not FULL: mem[COUNT] <= I_DATA; COUNT += 1; O_DATA holds; O_VALID = 0.
REQ-017 PUSH when FULL: memory and COUNT unchanged; ERROR = 1 next cycle; no wrap-around overwrite.
REQ-018 POP when not EMPTY: O_DATA <= mem[COUNT-1]; COUNT -= 1; O_VALID = 1 next cycle.
REQ-019 POP when EMPTY: no state change; O_DATA holds; ERROR = 1.
REQ-020 GET with INDEX < COUNT: O_DATA <= mem[COUNT-1-INDEX]; COUNT unchanged; O_VALID = 1.
REQ-021 GET with INDEX >= COUNT, including any GET when EMPTY: O_DATA holds; ERROR = 1.
REQ-022 CLEAR: COUNT <= 0; memory contents need not be cleared; O_DATA holds; never errors.
REQ-023 REPLACE when not EMPTY: mem[COUNT-1] <= I_DATA; COUNT unchanged.
REQ-024 REPLACE when EMPTY: no state change; ERROR = 1.
REQ-025 Reserved codes act as NOP and pulse ERROR.
REQ-026 Read latency: result on O_DATA and O_VALID exactly one cycle after the sampling edge; O_DATA holds its last value until the next successful POP or GET.
REQ-027 ERROR and O_VALID are never both 1; both are 0 after any NOP, PUSH, CLEAR or REPLACE that succeeds.
REQ-028 Index arithmetic is unsigned AW-bit arithmetic; COUNT-1-INDEX is evaluated only when the GET is legal, so no modular wrap is visible at the outputs.
REQ-029 Back-to-back commands on consecutive cycles are supported with no bubble; a POP directly after a PUSH returns the pushed word.

Reset
REQ-030 RESET low asynchronously forces COUNT = 0, O_DATA = 0, O_VALID = 0 and ERROR = 0, so EMPTY = 1 and FULL = 0.
REQ-031 Memory contents are undefined after reset and are never observable, because reads are legal only below COUNT.
REQ-032 Reset asserted mid-sequence aborts the in-flight command; the first command after reset release executes on the first rising edge with RESET high.

Verification
REQ-033 Defaults, after reset: PUSH 3, 5, 9; GET INDEX=0 -> O_DATA 9; GET INDEX=2 -> O_DATA 3 with O_VALID=1; COUNT = 3.
REQ-034 Fill and overflow: PUSH 8 words 0..7 -> FULL=1, COUNT=8; 9th PUSH -> ERROR=1, COUNT stays 8; POP -> O_DATA 7.
REQ-035 Drain and underflow: POP 8 times -> O_DATA 7..0, EMPTY=1; further POP -> ERROR=1, O_DATA stays 0; GET INDEX=0 -> ERROR=1.
REQ-036 Bad index, REPLACE and CLEAR: PUSH A, B; GET INDEX=2 -> ERROR=1; REPLACE C; POP -> C; CLEAR -> COUNT=0, EMPTY=1.
REQ-037 Async reset: hold RESET low between clock edges after 4 PUSHes -> COUNT=0 and O_DATA=0 immediately, without waiting for an edge.
REQ-038 Parameter sweep: repeat REQ-033..REQ-035 with WIDTH=16, DEPTH=32 and WIDTH=1, DEPTH=2, using scaled values.
